// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer and the decode
// controller that drives it.
package pc_seq_pkg;

  // Next-PC select encoding driven by the decode controller.
  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_RET    = 2'b11
  } pc_sel_e;

  // Instruction field positions.
  localparam int BOFF_MSB  = 7;
  localparam int JADDR_MSB = 11;
  localparam int INSTR_W   = 19;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the decode controller (master) and the
// program-counter sequencer (slave).
interface pc_sequencer_if
  import pc_seq_pkg::*;
#(
  parameter int AW    = 12,
  parameter int DEPTH = 8
);
  logic                     hold;
  logic [INSTR_W-1:0]       instruction;
  logic [1:0]               pc_mux;
  logic                     push;
  logic                     pop;
  logic [AW-1:0]            pc;
  logic [$clog2(DEPTH):0]   sp;
  logic                     stack_full;
  logic                     stack_empty;
  logic                     overflow;
  logic                     underflow;

  modport master (
    output hold, instruction, pc_mux, push, pop,
    input  pc, sp, stack_full, stack_empty, overflow, underflow
  );

  modport slave (
    input  hold, instruction, pc_mux, push, pop,
    output pc, sp, stack_full, stack_empty, overflow, underflow
  );
endinterface

// File: rtl/pc_sequencer_return_stack.sv
// DEPTH x AW return-address LIFO. Contents are never cleared; only the
// stack pointer is reset. Error strobes are combinational and are
// accumulated into sticky flags by the parent.
module return_stack #(
  parameter int AW    = 12,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [AW-1:0]            wdata_i,
  output logic [AW-1:0]            top_o,
  output logic [$clog2(DEPTH):0]   sp_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     ovf_o,
  output logic                     unf_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int SW = PW + 1;
  localparam logic [SW-1:0] SP_ONE  = SW'(1);
  localparam logic [SW-1:0] SP_FULL = SW'(DEPTH);
  localparam logic [PW-1:0] IDX_ONE = PW'(1);

  logic [AW-1:0] mem_q [DEPTH];
  logic [SW-1:0] sp_q, sp_d;
  logic [PW-1:0] wr_idx, top_idx;
  logic          full, empty, do_push, do_pop;

  assign full    = (sp_q == SP_FULL);
  assign empty   = (sp_q == '0);
  // Pop wins over a simultaneous push; the dropped push is flagged.
  assign do_pop  = pop_i & ~empty;
  assign do_push = push_i & ~pop_i & ~full;
  assign ovf_o   = push_i & (pop_i | full);
  assign unf_o   = pop_i & empty;

  // At sp == DEPTH the low bits wrap to 0, so sp-1 still lands on DEPTH-1.
  assign wr_idx  = sp_q[PW-1:0];
  assign top_idx = sp_q[PW-1:0] - IDX_ONE;
  assign top_o   = mem_q[top_idx];
  assign sp_o    = sp_q;
  assign full_o  = full;
  assign empty_o = empty;

  // Stack pointer next-state.
  always_comb begin
    sp_d = sp_q;
    if (do_pop)       sp_d = sp_q - SP_ONE;
    else if (do_push) sp_d = sp_q + SP_ONE;
  end

  // Stack pointer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     sp_q <= '0;
    else if (en_i) sp_q <= sp_d;
  end

  // Entry storage, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (en_i && do_push) mem_q[wr_idx] <= wdata_i;
  end
endmodule

// File: rtl/pc_sequencer.sv
// Program counter, next-PC mux and return-address stack for the 19-bit
// single-cycle core. The decode controller has already resolved branch
// conditions; this block only follows pc_mux.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int            AW       = 12,
  parameter int            DEPTH    = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);
  localparam int SW = $clog2(DEPTH) + 1;
  localparam logic [AW-1:0] PC_ONE = AW'(1);

  logic [AW-1:0]           pc_q, pc_d;
  logic [AW-1:0]           seq, boff, jaddr, top;
  logic [AW+JADDR_MSB:0]   jaddr_wide;
  logic [SW-1:0]           sp;
  logic                    full, empty, stk_ovf, stk_unf, en, ret_empty;
  logic                    overflow_q, overflow_d, underflow_q, underflow_d;
  logic                    unused_bits;

  assign en   = ~bus.hold;
  assign seq  = pc_q + PC_ONE;
  assign boff = {{(AW-BOFF_MSB-1){bus.instruction[BOFF_MSB]}},
                 bus.instruction[BOFF_MSB:0]};
  // Padding then slicing gives zero-extension or truncation for any AW.
  assign jaddr_wide  = {{AW{1'b0}}, bus.instruction[JADDR_MSB:0]};
  assign jaddr       = jaddr_wide[AW-1:0];
  assign unused_bits = ^{jaddr_wide[AW+JADDR_MSB:AW],
                         bus.instruction[INSTR_W-1:JADDR_MSB+1]};

  return_stack #(.AW(AW), .DEPTH(DEPTH)) u_stack (
    .clk     (clk),
    .reset   (reset),
    .en_i    (en),
    .push_i  (bus.push),
    .pop_i   (bus.pop),
    .wdata_i (seq),
    .top_o   (top),
    .sp_o    (sp),
    .full_o  (full),
    .empty_o (empty),
    .ovf_o   (stk_ovf),
    .unf_o   (stk_unf)
  );

  // Next-PC select and sticky error accumulation.
  always_comb begin
    pc_d      = seq;
    ret_empty = 1'b0;
    case (bus.pc_mux)
      PC_SEQ:    pc_d = seq;
      PC_BRANCH: pc_d = seq + boff;
      PC_JUMP:   pc_d = jaddr;
      PC_RET: begin
        if (empty) ret_empty = 1'b1;
        else       pc_d      = top;
      end
      default:   pc_d = seq;
    endcase
    overflow_d  = overflow_q | stk_ovf;
    underflow_d = underflow_q | stk_unf | ret_empty;
  end

  // PC and sticky flag registers; hold freezes everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (en) begin
      pc_q        <= pc_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.sp          = sp;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Holds the program counter and the hardware return-address stack for the single-cycle 19-bit core.
- Sits directly downstream of the instruction-decode controller. It consumes that controller's pc_mux, push and pop outputs plus the current instruction word.
- Produces the fetch address that drives instruction memory.
- Reports stack health (full, empty, sticky overflow and underflow) to the debug and status logic.

Parameters:
- AW, 12, PC and instruction-memory address width (AW >= 8).
- DEPTH, 8, number of return-stack entries (power of 2, >= 2).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- hold  in  1  freezes PC, stack and flags when 1; all other inputs are ignored.
- instruction  in  19  word currently fetched at pc.
- pc_mux  in  2  next-PC select: 00 seq, 01 branch, 10 jump/call, 11 return.
- push  in  1  push return address (call).
- pop  in  1  pop return address (return).
- pc  out  AW  registered fetch address.
- sp  out  $clog2(DEPTH)+1  current stack occupancy, 0..DEPTH.
- stack_full  out  1  sp == DEPTH (combinational from sp).
- stack_empty  out  1  sp == 0 (combinational from sp).
- overflow  out  1  sticky: a push was attempted while full.
- underflow  out  1  sticky: a pop was attempted while empty.

Behaviour:
- Clock and reset (already decided): one clock, clk; reset is asynchronous and active-high, port name reset.
- On reset assertion, immediately: pc=RESET_PC, sp=0, overflow=0, underflow=0. Stack contents are don't-care and are not cleared.
- A reset asserted mid-operation aborts any pending update. The first edge after reset deasserts uses pc=RESET_PC.
- All state updates on rising clk when hold=0. When hold=1, all state is unchanged.
- Intermediate values (all arithmetic modulo 2^AW, wrap-around silent):
  - seq = pc+1
  - boff = sign-extended instruction[7:0]
  - jaddr = instruction[11:0], zero-extended or truncated to AW
- Next PC by pc_mux:
  - 00: seq.
  - 01: seq + boff. The controller has already resolved the branch condition; this block never inspects flags.
  - 10: jaddr.
  - 11: value on top of stack (stack[sp-1]). If empty: seq, and underflow is set.
- Push (push=1, pop=0):
  - If not full: stack[sp] <= seq; sp <= sp+1.
  - If full: stack and sp unchanged, overflow <= 1. The PC still follows pc_mux (the call is taken).
- Pop (pop=1, push=0):
  - If not empty: sp <= sp-1.
  - If empty: sp unchanged, underflow <= 1.
- push=1 and pop=1 together is illegal. Pop takes priority, push is ignored, and overflow is set as an error indicator.
- Push at sp=DEPTH-1 is legal: sp becomes DEPTH and stack_full asserts the next cycle.
- pop=1 with pc_mux!=11: stack pops, and the PC follows pc_mux.
- pc_mux=11 with pop=0: PC takes the top of stack, but sp is unchanged.
- Latency: one cycle from instruction to PC change; pc is valid the cycle after the edge.
- sp, stack_full and stack_empty reflect state after the most recent edge.
- Sticky flags clear only on reset.

Decomposition:
- Shared package pc_seq_pkg holds:
  - PC_SEQ=2'b00, PC_BRANCH=2'b01, PC_JUMP=2'b10, PC_RET=2'b11
  - Field constants BOFF_MSB=7, JADDR_MSB=11, INSTR_W=19
- The decode controller imports the same package.
- One sub-module, return_stack: a DEPTH x AW LIFO with push, pop, top, sp, full, empty and overflow/underflow strobes.
- pc_sequencer wraps return_stack with the PC register and the next-PC mux.

Test Plan:
- Reset and sequential fetch: assert reset mid-run → pc=0 immediately; release, 3 edges with pc_mux=00 → pc=1,2,3; sp=0, stack_empty=1.
- Branch both signs with pc=0x010:
  - instruction[7:0]=0x05 → pc=0x016.
  - From pc=0x016, offset 0xFA (-6) → pc=0x011.
  - From pc=0xFFF, pc_mux=00 → pc wraps to 0x000.
- Call/return: at pc=0x020, pc_mux=10, push=1, jaddr=0x300 → pc=0x300, sp=1. Next pc_mux=11, pop=1 → pc=0x021, sp=0.
- Overflow: 8 consecutive calls → sp=8, stack_full=1. 9th call to 0x100 → pc=0x100, sp stays 8, overflow=1. Then 8 returns unwind the correct addresses in LIFO order.
- Underflow: from reset, pc=0x005, pc_mux=11, pop=1 → pc=0x006, sp=0, underflow=1; flag stays set until reset.
- Hold and illegal input:
  - hold=1 for 3 edges with pc_mux=10, push=1 → pc and sp unchanged.
  - push=1 and pop=1 together at sp=2 → sp=1, overflow=1.
